// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared main-memory port between the I-cache refill
// engine and the D-cache refill/write-through engine; sequences line bursts.
module mem_port_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  localparam int BW = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;   // 1 = D-side
  logic            last_q, last_d;     // 1 = D-side was granted last
  logic [AW-3:0]   waddr_q, waddr_d;   // word address of the transaction
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            i_rvalid_q, i_rvalid_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            grant_i;
  logic            last_beat;
  logic            in_burst;
  logic            busy;
  logic            unused_addr_bits;

  // Byte-offset bits of requester addresses play no part in word beats.
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    waddr_d    = waddr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    beat_d     = beat_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_i    = 1'b0;
    last_beat  = we_q || (beat_q == BW'(LINE_WORDS - 1));

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // On a tie the side that did not win last time gets the port.
          grant_i = i_req && (!d_req || last_q);
          owner_d = !grant_i;
          waddr_d = grant_i ? i_addr[AW-1:2] : d_addr[AW-1:2];
          we_d    = !grant_i && d_we;
          wdata_d = grant_i ? '0 : d_wdata;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (mem_ready) begin
          if (!we_q) begin
            if (owner_q) begin
              d_rvalid_d = 1'b1;
              d_rdata_d  = mem_rdata;
            end else begin
              i_rvalid_d = 1'b1;
              i_rdata_d  = mem_rdata;
            end
          end
          if (last_beat) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      waddr_q    <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      beat_q     <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      waddr_q    <= waddr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      beat_q     <= beat_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign in_burst = (state_q == BURST);
  assign busy     = (state_q != IDLE);

  // Read beats walk the line from its base; writes address the single word.
  assign mem_req   = in_burst;
  assign mem_we    = in_burst && we_q;
  assign mem_addr  = !in_burst ? '0 :
                     we_q      ? {waddr_q, 2'b00} :
                                 {waddr_q[AW-3:BW], beat_q, 2'b00};
  assign mem_wdata = (in_burst && we_q) ? wdata_q : '0;

  assign i_gnt    = busy && !owner_q;
  assign d_gnt    = busy && owner_q;
  assign i_done   = (state_q == DONE) && !owner_q;
  assign d_done   = (state_q == DONE) && owner_q;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions scored against a transaction-level model of arbitration and bursts.
module tb_mem_port_arbiter;

  localparam int LW = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid, i_done;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid, d_done;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LINE_WORDS(LW), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // Memory returns address-derived data in the accepting cycle.
  always_comb mem_rdata = mem_val(mem_addr);

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          last_d_side = 1'b1;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  bit          exp_we;
  logic [31:0] exp_wdata;
  bit          pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beats of one transaction, derived from the addressing rules.
  task automatic load_txn(input int side, input logic [31:0] ia, input logic [31:0] da,
                          input logic [31:0] dwd, input bit dwe);
    logic [31:0] base;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_wdata = dwd;
    if (side == 1 && dwe) begin
      exp_we = 1'b1;
      exp_addr_q.push_back({da[31:2], 2'b00});
    end else begin
      exp_we = 1'b0;
      base = ((side == 1) ? da : ia) & ~(32'(LW * 4) - 32'd1);
      for (int k = 0; k < LW; k++) begin
        exp_addr_q.push_back(base + 32'(4 * k));
        exp_data_q.push_back(mem_val(base + 32'(4 * k)));
      end
    end
  endtask

  // mode: 0 = mem_ready always 1 (latency checked), 1 = random, 2 = fixed wait pattern.
  // Must be called at a negedge; returns at the negedge of the IDLE cycle after the last done.
  task automatic round(input bit ri, input bit rd, input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] dwd, input bit dwe, input int mode);
    int          order[$];
    int          cur, t_ref, pidx, lat;
    bit          own, rdy, stalled, rv, dn;
    logic [31:0] saddr, rdv;
    if (ri && rd) begin
      if (last_d_side) begin order.push_back(0); order.push_back(1); end
      else             begin order.push_back(1); order.push_back(0); end
    end else if (ri) order.push_back(0);
    else             order.push_back(1);
    i_addr = ia; d_addr = da; d_wdata = dwd; d_we = dwe;
    i_req = ri; d_req = rd;
    cur = 0; t_ref = 0; pidx = 0; stalled = 1'b0; saddr = '0;
    load_txn(order[0], ia, da, dwd, dwe);
    for (int c = 1; c <= 400 && cur < order.size(); c++) begin
      @(negedge clk);
      own = (order[cur] == 1);
      if (own) check("i_quiet", {i_gnt, i_rvalid, i_done}, 0);
      else     check("d_quiet", {d_gnt, d_rvalid, d_done}, 0);
      if (stalled) begin
        check("hold_req", mem_req, 1);
        check("hold_addr", mem_addr, saddr);
      end
      rv  = own ? d_rvalid : i_rvalid;
      rdv = own ? d_rdata  : i_rdata;
      if (rv) begin
        if (exp_data_q.size() == 0) check("extra_rvalid", rv, 0);
        else check("rdata", rdv, exp_data_q.pop_front());
      end
      dn = own ? d_done : i_done;
      if (dn) begin
        check("beats_left", exp_addr_q.size(), 0);
        check("rvalid_left", exp_data_q.size(), 0);
        check("gnt_at_done", own ? d_gnt : i_gnt, 1);
        lat = exp_we ? 2 : LW + 1;
        if (mode == 0) check("done_cycle", c, t_ref + lat);
        if (own) d_req = 1'b0; else i_req = 1'b0;
        last_d_side = own;
        t_ref = c + 1;
        cur++;
        if (cur < order.size()) load_txn(order[cur], ia, da, dwd, dwe);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = (pidx < 7) ? pat[pidx] : 1'b1;
      endcase
      mem_ready = rdy;
      if (mem_req) begin
        pidx++;
        check("gnt_with_req", own ? d_gnt : i_gnt, 1);
        if (rdy) begin
          if (exp_addr_q.size() == 0) check("extra_beat", mem_req, 0);
          else begin
            check("mem_addr", mem_addr, exp_addr_q.pop_front());
            check("mem_we", mem_we, exp_we);
            if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
          end
        end
      end
      stalled = mem_req && !rdy;
      saddr   = mem_addr;
    end
    check("all_done", cur, order.size());
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    check("idle_after", {mem_req, i_gnt, d_gnt}, 0);
  endtask

  initial begin
    #12;
    check("rst_ctrl", {i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, mem_req, mem_we}, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    check("rst_mem", {mem_addr, mem_wdata}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Tie after reset goes to I, then D.
    round(1, 1, 32'h0000_4444, 32'h0000_8888, 32'h0, 0, 0);
    // Single I refill; leaves last_grant = I.
    round(1, 0, 32'h0000_1238, 32'h0, 32'h0, 0, 0);
    // Tie now goes to D first.
    round(1, 1, 32'h0000_5000, 32'h0000_6004, 32'h0, 0, 0);
    // Write-through.
    round(0, 1, 32'h0, 32'h0000_2002, 32'hDEAD_BEEF, 1, 0);
    // D refill with wait states.
    round(0, 1, 32'h0, 32'h0000_3014, 32'h0, 0, 2);
    // Back-to-back I refills.
    round(1, 0, 32'h0000_7010, 32'h0, 32'h0, 0, 0);
    round(1, 0, 32'h0000_7020, 32'h0, 32'h0, 0, 0);

    repeat (40) begin
      bit ri, rd;
      ri = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!ri && !rd) rd = 1'b1;
      round(ri, rd, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)));
    end

    // Reset in the middle of an I burst.
    i_addr = 32'h0000_9000; i_req = 1'b1; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_rvalid", i_rvalid, 1);
    rst = 1'b0;
    #1;
    check("rst_mid_drop", {mem_req, i_gnt, i_rvalid}, 0);
    i_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_mid_quiet", {i_done, i_gnt, d_done, d_gnt, mem_req}, 0);
    end
    last_d_side = 1'b1;
    rst = 1'b1;
    round(1, 1, 32'h0000_A00C, 32'h0000_B000, 32'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
